// File: rtl/clk_en_sequencer.sv
// rtl/clk_en_sequencer.sv - PLL lock sequencer and core clock-enable generator (optional pause: CLKEN_PAUSE_EN)
module clk_en_sequencer #(
    parameter int HOLDOFF_CYCLES = 1024,
    parameter int ACC_W          = 16,
    parameter int SND_INC        = 2386
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic pll_locked,
`ifdef CLKEN_PAUSE_EN
    input  logic pause,
`endif
    output logic core_rst_n,
    output logic running,
    output logic ce_pix,
    output logic ce_cpu,
    output logic ce_snd
);

    localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [ACC_W:0]   SND_STEP = (ACC_W + 1)'(SND_INC);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLDOFF   = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         div_q, div_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               core_rst_n_q, core_rst_n_d;
    logic               running_q, running_d;
    logic               ce_pix_q, ce_pix_d;
    logic               ce_cpu_q, ce_cpu_d;
    logic               ce_snd_q, ce_snd_d;

    logic               lk_s;
    logic               run_now;
    logic               run_next;
    logic               cpu_hold;
    logic [ACC_W:0]     acc_sum;

    // Synchroniser, lock FSM, divider, sound accumulator and registered output terms
    always_comb begin
        sync1_d  = pll_locked;
        sync2_d  = sync1_q;
        lk_s     = sync2_q;
        state_d  = state_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_WAIT_LOCK: begin
                if (lk_s) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = '0;
                end
            end
            ST_HOLDOFF: begin
                // Lock loss takes priority over the terminal count
                if (!lk_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            ST_RUN: begin
                if (!lk_s) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase

        run_now  = (state_q == ST_RUN);
        // Outputs track the next state so lock loss drops them with no extra delay
        run_next = (state_d == ST_RUN);

`ifdef CLKEN_PAUSE_EN
        cpu_hold = pause;
`else
        cpu_hold = 1'b0;
`endif

        acc_sum = {1'b0, acc_q} + SND_STEP;

        div_d = run_now ? 4'(div_q + 4'd1) : 4'd0;

        if (!run_now) begin
            acc_d = '0;
        end else if (cpu_hold) begin
            acc_d = acc_q;
        end else begin
            acc_d = acc_sum[ACC_W-1:0];
        end

        core_rst_n_d = run_next;
        running_d    = run_next;
        ce_pix_d     = run_now && run_next && (div_q[2:0] == 3'd7);
        ce_cpu_d     = run_now && run_next && (div_q == 4'd15) && !cpu_hold;
        ce_snd_d     = run_now && run_next && acc_sum[ACC_W] && !cpu_hold;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q      <= ST_WAIT_LOCK;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            div_q        <= 4'd0;
            acc_q        <= '0;
            core_rst_n_q <= 1'b0;
            running_q    <= 1'b0;
            ce_pix_q     <= 1'b0;
            ce_cpu_q     <= 1'b0;
            ce_snd_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            acc_q        <= acc_d;
            core_rst_n_q <= core_rst_n_d;
            running_q    <= running_d;
            ce_pix_q     <= ce_pix_d;
            ce_cpu_q     <= ce_cpu_d;
            ce_snd_q     <= ce_snd_d;
        end
    end

    assign core_rst_n = core_rst_n_q;
    assign running    = running_q;
    assign ce_pix     = ce_pix_q;
    assign ce_cpu     = ce_cpu_q;
    assign ce_snd     = ce_snd_q;

endmodule
